// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core; drives datapath selects/enables and the ALU_Control hints.
// Latency: 2-5 cycles per instruction (FETCH..last state); outputs decode state_q combinationally.
// Backpressure: none, the FSM advances every cycle; rst_i forces RESET asynchronously.
module multicycle_control_fsm (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] opcode_i,
    input  logic       zero_i,
    output logic       pc_write_o,
    output logic       adr_src_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic [1:0] result_src_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic       reg_write_o,
    output logic [2:0] imm_src_o,
    output logic [1:0] ALU_CO_o,
    output logic       is_immediate_o,
    output logic       illegal_o
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [3:0] S_RESET    = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEMADR   = 4'd3;
    localparam logic [3:0] S_MEMREAD  = 4'd4;
    localparam logic [3:0] S_MEMWB    = 4'd5;
    localparam logic [3:0] S_MEMWRITE = 4'd6;
    localparam logic [3:0] S_EXECR    = 4'd7;
    localparam logic [3:0] S_EXECI    = 4'd8;
    localparam logic [3:0] S_ALUWB    = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;
    localparam logic [3:0] S_JAL      = 4'd11;
    localparam logic [3:0] S_LUI      = 4'd12;

    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic [1:0] alu_co;
        logic       is_imm;
    } ctrl_t;

    logic [3:0] state_q, state_d;
    logic       rst_hold_q, rst_hold_d;
    ctrl_t      ctrl;
    logic       opcode_legal;

    always_comb begin
        opcode_legal = 1'b0;
        case (opcode_i)
            OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, OP_LUI: opcode_legal = 1'b1;
            default:                                          opcode_legal = 1'b0;
        endcase
    end

    // rst_hold_q keeps the FSM in RESET for one full cycle after release,
    // so the first FETCH lands on the second rising edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_RESET;
            rst_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            rst_hold_q <= rst_hold_d;
        end
    end

    always_comb begin
        rst_hold_d = 1'b0;
        state_d    = S_FETCH;
        case (state_q)
            S_RESET:  state_d = rst_hold_q ? S_RESET : S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    OP_LUI:       state_d = S_LUI;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (opcode_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_LUI:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl       = '0;
        pc_write_o = 1'b0;
        illegal_o  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ctrl.ir_write   = 1'b1;
                ctrl.alu_src_b  = 2'b10;
                ctrl.result_src = 2'b10;
                pc_write_o      = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_a = 2'b01;
                ctrl.alu_src_b = 2'b01;
                illegal_o      = ~opcode_legal;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_src_b = 2'b01;
            end
            S_MEMREAD:  ctrl.adr_src = 1'b1;
            S_MEMWB: begin
                ctrl.result_src = 2'b01;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXECR: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_co    = 2'b10;
            end
            S_EXECI: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_co    = 2'b10;
                ctrl.is_imm    = 1'b1;
            end
            S_ALUWB:    ctrl.reg_write = 1'b1;
            S_BEQ: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_co    = 2'b01;
                pc_write_o     = zero_i;
            end
            S_JAL: begin
                ctrl.alu_src_a = 2'b01;
                ctrl.alu_src_b = 2'b10;
                pc_write_o     = 1'b1;
            end
            S_LUI: begin
                ctrl.alu_src_a = 2'b11;
                ctrl.alu_src_b = 2'b01;
            end
            default: ctrl = '0;
        endcase
    end

    // Immediate format follows the opcode live, but is held at 0 while in reset.
    always_comb begin
        imm_src_o = 3'b000;
        if (!rst_i && state_q != S_RESET) begin
            case (opcode_i)
                OP_SW:   imm_src_o = 3'b001;
                OP_BEQ:  imm_src_o = 3'b010;
                OP_JAL:  imm_src_o = 3'b011;
                OP_LUI:  imm_src_o = 3'b100;
                default: imm_src_o = 3'b000;
            endcase
        end
    end

    assign adr_src_o      = ctrl.adr_src;
    assign mem_write_o    = ctrl.mem_write;
    assign ir_write_o     = ctrl.ir_write;
    assign result_src_o   = ctrl.result_src;
    assign alu_src_a_o    = ctrl.alu_src_a;
    assign alu_src_b_o    = ctrl.alu_src_b;
    assign reg_write_o    = ctrl.reg_write;
    assign ALU_CO_o       = ctrl.alu_co;
    assign is_immediate_o = ctrl.is_imm;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-instruction cycle tables checked every cycle, with
// directed opcodes, a randomized instruction stream and an asynchronous reset mid-instruction.
module tb_multicycle_control_fsm;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [6:0] opcode_i;
    logic       zero_i;
    logic       pc_write_o, adr_src_o, mem_write_o, ir_write_o, reg_write_o;
    logic [1:0] result_src_o, alu_src_a_o, alu_src_b_o, ALU_CO_o;
    logic [2:0] imm_src_o;
    logic       is_immediate_o, illegal_o;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_control_fsm dut (
        .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .zero_i(zero_i),
        .pc_write_o(pc_write_o), .adr_src_o(adr_src_o), .mem_write_o(mem_write_o),
        .ir_write_o(ir_write_o), .result_src_o(result_src_o), .alu_src_a_o(alu_src_a_o),
        .alu_src_b_o(alu_src_b_o), .reg_write_o(reg_write_o), .imm_src_o(imm_src_o),
        .ALU_CO_o(ALU_CO_o), .is_immediate_o(is_immediate_o), .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [6:0] LW  = 7'b0000011, SW  = 7'b0100011, RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011, BEQ = 7'b1100011, JAL = 7'b1101111;
    localparam logic [6:0] LUI = 7'b0110111, BAD = 7'b1111111;

    // {pc_write, adr_src, mem_write, ir_write, result_src, src_a, src_b, reg_write, imm_src, ALU_CO, is_imm, illegal}
    wire [17:0] obs = {pc_write_o, adr_src_o, mem_write_o, ir_write_o, result_src_o,
                       alu_src_a_o, alu_src_b_o, reg_write_o, imm_src_o, ALU_CO_o,
                       is_immediate_o, illegal_o};

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    function automatic bit legal(input logic [6:0] op);
        return op == LW || op == SW || op == RT || op == IT || op == BEQ || op == JAL || op == LUI;
    endfunction

    function automatic int ncyc(input logic [6:0] op);
        if (op == LW)   return 5;
        if (op == BEQ)  return 3;
        if (!legal(op)) return 2;
        return 4;
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            SW:      return 3'b001;
            BEQ:     return 3'b010;
            JAL:     return 3'b011;
            LUI:     return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Expected outputs in cycle k (1 = FETCH) of instruction op; cur is the opcode on the pins now.
    function automatic logic [17:0] exp_vec(input logic [6:0] op, input int k, input logic z,
                                            input logic [6:0] cur);
        logic pcw, adr, mw, irw, rw, isi, ill;
        logic [1:0] res, sa, sb, co;
        {pcw, adr, mw, irw, rw, isi, ill} = '0;
        {res, sa, sb, co} = '0;
        if (k == 1) begin
            pcw = 1; irw = 1; sb = 2'b10; res = 2'b10;
        end else if (k == 2) begin
            sa = 2'b01; sb = 2'b01; ill = !legal(op);
        end else if (op == LW || op == SW) begin
            if (k == 3) begin sa = 2'b10; sb = 2'b01; end
            else if (k == 4) begin adr = 1; mw = (op == SW); end
            else begin res = 2'b01; rw = 1; end
        end else if (k == 4) begin
            rw = 1;
        end else begin
            case (op)
                RT:  begin sa = 2'b10; sb = 2'b00; co = 2'b10; end
                IT:  begin sa = 2'b10; sb = 2'b01; co = 2'b10; isi = 1; end
                BEQ: begin sa = 2'b10; co = 2'b01; pcw = z; end
                JAL: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
                LUI: begin sa = 2'b11; sb = 2'b01; end
                default: ;
            endcase
        end
        return {pcw, adr, mw, irw, res, sa, sb, rw, imm_of(cur), co, isi, ill};
    endfunction

    // Runs one instruction starting at its FETCH cycle; zmode 0/1 forces zero_i, 2 randomizes.
    // stop_at > 0 ends after that cycle's check. Opcode is scrambled where it must be ignored.
    task automatic run_instr(input string tag, input logic [6:0] op, input int zmode, input int stop_at);
        int n = ncyc(op);
        if (stop_at > 0) n = stop_at;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk_i);
            if (k <= 3 && (k != 3 || op == LW || op == SW)) opcode_i = op;
            else if ($urandom_range(1, 0) == 1) opcode_i = 7'($urandom);
            zero_i = (zmode == 2) ? 1'($urandom_range(1, 0)) : (zmode == 1);
            #1;
            check($sformatf("%s_c%0d", tag, k), obs, exp_vec(op, k, zero_i, opcode_i));
        end
    endtask

    task automatic release_reset(input string tag);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1 check({tag, "_release"}, obs, 18'h0);
        @(negedge clk_i);
        #1 check({tag, "_reset_cycle"}, obs, 18'h0);
    endtask

    always @(negedge clk_i) begin
        if (rst_i === 1'b1)
            check("we_in_reset", {14'h0, pc_write_o, mem_write_o, ir_write_o, reg_write_o}, 18'h0);
    end

    logic [6:0] pool [8];

    initial begin
        rst_i    = 1'b1;
        opcode_i = LW;
        zero_i   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            #1 check("reset_hold", obs, 18'h0);
        end
        release_reset("rst0");

        run_instr("lw", LW, 2, 0);
        run_instr("sw", SW, 2, 0);
        run_instr("rtype", RT, 2, 0);
        run_instr("itype", IT, 2, 0);
        run_instr("lui", LUI, 2, 0);
        run_instr("beq_z1", BEQ, 1, 0);
        run_instr("beq_z0", BEQ, 0, 0);
        run_instr("jal", JAL, 2, 0);
        run_instr("illegal", BAD, 2, 0);
        run_instr("after_ill", RT, 2, 0);

        pool = '{LW, SW, RT, IT, BEQ, JAL, LUI, BAD};
        for (int i = 0; i < 60; i++) begin
            logic [6:0] op;
            op = pool[$urandom_range(7, 0)];
            if (op == BAD) op = 7'($urandom);
            run_instr($sformatf("rnd%0d", i), op, 2, 0);
        end

        // Asynchronous reset in the middle of MEMREAD.
        run_instr("lw_cut", LW, 2, 4);
        opcode_i = LW;
        #2 rst_i = 1'b1;
        #1 check("async_rst", obs, 18'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            #1 check("rst_mid_hold", obs, 18'h0);
        end
        release_reset("rst1");
        run_instr("post_rst_sw", SW, 2, 0);
        run_instr("post_rst_jal", JAL, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
